piso_shift_ctrl: RTL
====================

// Module: piso_shift_ctrl
// PURPOSE
//  Sequencer for the WIDTH-stage PISO register built from D_flipFlop cells.
//  - Accepts parallel words over a valid/ready handshake.
//  - Drives the register's load and shift enables.
//  - Frames the serial bitstream for a downstream consumer that can stall.
//  - Holds only control state; the data bits live in the PISO datapath.
// PARAMETERS
//  WIDTH       4  bits per word = number of PISO stages (>=2)
//  GAP_CYCLES  0  idle cycles forced between words (0..15)
//  CNT_W       8  width of the words_done counter
// PORTS
//  clk          in   1      rising-edge clock, single domain
//  rst          in   1      synchronous reset, active-high
//  par_valid    in   1      upstream has a parallel word on the datapath inputs
//  par_ready    out  1      controller can load a word this cycle
//  piso_load    out  1      PISO parallel-load enable (captures on this edge)
//  piso_shift   out  1      PISO shift enable (advances one bit on this edge)
//  ser_ready    in   1      downstream accepts the current serial bit
//  ser_valid    out  1      PISO serial output (q) holds a valid bit
//  ser_first    out  1      current bit is bit 0 of the word
//  ser_last     out  1      current bit is bit WIDTH-1 of the word
//  busy         out  1      state != IDLE
//  words_done   out  CNT_W  count of fully transmitted words, wraps
// BEHAVIOUR
//  - Clock and reset: single clock clk; reset is synchronous and active-high on rst.
//  - Reset: on any edge with rst=1, state<=IDLE, bit_cnt<=0, gap_cnt<=0, words_done<=0.
//    - While rst=1: piso_load, piso_shift, par_ready and ser_valid are forced to 0.
//    - Mid-word reset drops the in-flight word; no ser_last is produced for it.
//  - States: IDLE, SHIFT, GAP.
//  - IDLE: par_ready=1, ser_valid=0.
//    - piso_load = par_valid & par_ready.
//    - On load: ->SHIFT with bit_cnt=0.
//  - SHIFT: ser_valid=1.
//    - ser_first = (bit_cnt==0); ser_last = (bit_cnt==WIDTH-1).
//    - beat = ser_valid & ser_ready; piso_shift = beat.
//    - On a non-last beat: bit_cnt++.
//    - ser_ready=0 stalls: bit_cnt and the PISO contents hold; ser_* outputs stay stable.
//    - Last beat: words_done++ (wraps at 2^CNT_W).
//      - GAP_CYCLES=0: ->IDLE, or back-to-back (see below).
//      - GAP_CYCLES>0: ->GAP, gap_cnt<=GAP_CYCLES-1.
//  - Back-to-back (GAP_CYCLES=0 only):
//    - In SHIFT, par_ready = ser_last & ser_ready. This is combinational from ser_ready.
//    - If par_valid is also high, piso_load=1 and piso_shift=1 on the same edge; load wins in the datapath.
//    - State stays SHIFT with bit_cnt<=0, giving zero dead cycles.
//  - GAP: par_ready=0, ser_valid=0. gap_cnt decrements; at 0, ->IDLE.
//  - Latency: the word's bit 0 is valid on the cycle after the load edge.
//    - Throughput: 1 word per WIDTH cycles when GAP_CYCLES=0 and there are no stalls.
//  - Outputs: all are functions of registered state plus the ready/valid inputs named above; no other input-to-output paths.
//  - Invariants:
//    - piso_shift is never asserted in IDLE or GAP.
//    - piso_load is never asserted in GAP.
//    - bit_cnt < WIDTH always.
// TESTING (WIDTH=4 unless noted)
//  1. Reset: hold rst=1 for 2 cycles with par_valid=1 -> piso_load=0, par_ready=0, busy=0, words_done=0.
//  2. Single word: par_valid pulse, ser_ready=1 ->
//     - piso_load for 1 cycle, then 4 cycles of ser_valid with piso_shift=1.
//     - ser_first on cycle 1, ser_last on cycle 4.
//     - Then IDLE; words_done=1.
//  3. Stall: deassert ser_ready during bit 2 for 3 cycles ->
//     - bit_cnt holds at 2, piso_shift=0, ser_valid stays 1.
//     - Completes after 7 SHIFT cycles total.
//  4. Back-to-back: par_valid held high for 3 words ->
//     - piso_load and piso_shift both high on each ser_last beat.
//     - 12 contiguous ser_valid cycles; words_done=3.
//  5. GAP_CYCLES=2, two words -> exactly 2 cycles with ser_valid=0 and par_ready=0, then IDLE accepts.
//  6. Mid-word reset at bit 1, then wrap ->
//     - busy=0 and ser_valid=0 one cycle after rst; no ser_last for the dropped word.
//     - CNT_W=2: 5 words leave words_done=1.

Source files
------------

// File: rtl/piso_shift_ctrl.sv
// Purpose: sequences load/shift enables of a WIDTH-stage PISO register and frames its serial stream.
// Latency: bit 0 is valid the cycle after the load edge; back-to-back words have no dead cycles.
// Backpressure: ser_ready=0 freezes bit_cnt and the PISO; par_ready is low until the word's last beat.
module piso_shift_ctrl #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             piso_load,
    output logic             piso_shift,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy,
    output logic [CNT_W-1:0] words_done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [3:0] GAP_INIT = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state, state_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [3:0]       gap_cnt, gap_cnt_nxt;
    logic [CNT_W-1:0] words_nxt;
    logic             beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            words_done <= '0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            words_done <= words_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        words_nxt   = words_done;
        par_ready   = 1'b0;
        piso_load   = 1'b0;
        piso_shift  = 1'b0;
        ser_valid   = 1'b0;
        ser_first   = 1'b0;
        ser_last    = 1'b0;
        beat        = 1'b0;

        case (state)
            IDLE: begin
                par_ready = 1'b1;
                piso_load = par_valid;
                if (par_valid) begin
                    state_nxt   = SHIFT;
                    bit_cnt_nxt = '0;
                end
            end
            SHIFT: begin
                ser_valid  = 1'b1;
                ser_first  = (bit_cnt == '0);
                ser_last   = (bit_cnt == LAST_BIT);
                beat       = ser_ready;
                piso_shift = beat;
                if (beat && !ser_last) begin
                    bit_cnt_nxt = bit_cnt + BW'(1);
                end else if (beat) begin
                    words_nxt   = words_done + CNT_W'(1);
                    bit_cnt_nxt = '0;
                    if (GAP_CYCLES == 0) begin
                        // Reload on the final beat; the datapath gives load priority over shift.
                        par_ready = 1'b1;
                        piso_load = par_valid;
                        state_nxt = par_valid ? SHIFT : IDLE;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_INIT;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (rst) begin
            par_ready  = 1'b0;
            piso_load  = 1'b0;
            piso_shift = 1'b0;
            ser_valid  = 1'b0;
            ser_first  = 1'b0;
            ser_last   = 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule
